bus_master_port: RTL

Master-side bus interface unit. It is the initiator that talks to the 4-way round-robin bus arbiter. It accepts one transfer command from local logic, raises `request`, and waits for `grant`. While it owns the bus it drives `busbusy` and performs a burst of 1-4 read or write beats with an acked handshake to the addressed slave. When the burst ends it drops both `request` and `busbusy` so the arbiter rotates priority and re-arbitrates. Four instances sit between the local masters and the shared bus, one per arbiter request/grant pair.

---
 rtl/bus_master_port.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bus_master_port.sv
// Bus master port: takes one local burst command, requests the arbiter, runs 1-4 acked beats, then releases.
// Optional ack-wait abort is enabled by defining BUS_TIMEOUT_EN.
module bus_master_port #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              error,
    output logic              request,
    input  logic              grant,
    output logic              busbusy,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;

    state_t            state, state_nxt;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        len_q;
    logic [1:0]        beat_q;
    logic              beat_ack;
    logic              last_beat;
    logic              abort;

    assign beat_ack  = (state == XFER) && bus_ack;
    assign last_beat = (beat_q == len_q);

`ifdef BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          err_q;

    // Abort on the cycle the count would reach TIMEOUT, so REL follows TIMEOUT cycles after XFER entry.
    assign abort = (state == XFER) && !bus_ack && (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= abort;
            if (state != XFER || bus_ack) to_cnt <= '0;
            else                          to_cnt <= to_cnt + 1'b1;
        end
    end

    assign error = err_q;
`else
    assign abort = 1'b0;
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = REQ;
            REQ:     if (grant) state_nxt = XFER;
            XFER:    if ((beat_ack && last_beat) || abort) state_nxt = REL;
            REL:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q     <= 1'b0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= beat_ack && !wr_q;
            if (beat_ack && !wr_q) rd_data <= bus_rdata;
            if (state == IDLE && cmd_valid) begin
                wr_q   <= cmd_write;
                addr_q <= cmd_addr;
                len_q  <= cmd_len;
                beat_q <= '0;
            end else if (beat_ack && !last_beat) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    // Bus-side outputs are gated by XFER so nothing leaks onto the shared bus outside ownership.
    always_comb begin
        cmd_ready = (state == IDLE) && rst;
        request   = (state == REQ) || (state == XFER);
        busbusy   = (state == XFER);
        bus_valid = (state == XFER);
        done      = (state == REL);
        wr_pop    = beat_ack && wr_q;
        bus_we    = (state == XFER) && wr_q;
        bus_addr  = (state == XFER) ? addr_q + ADDR_W'(beat_q) : '0;
        bus_wdata = (state == XFER) ? wr_data : '0;
    end

endmodule
